// File: rtl/tlm_sb_egress_arb.sv
// tlm_sb_egress_arb: IOSF sideband egress arbiter and credit manager.
// Round-robin arbitration at message granularity across N_REQ sources
// onto the single 8-bit tlm_sb2_* channel. Posted and non-posted fabric
// credits are tracked separately.
// Optional build macro TLM_SB_ARB_STALL_CNT_EN adds the arb_stall_cnt
// output, a saturating count of cycles lost to zero credit.

// Credit counter for one class. A returned credit only becomes usable
// once it is in the register, so there is no cup -> ready path.
module tlm_sb_cred_ctr #(
  parameter int MAX = 8,
  localparam int W  = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cup,
  input  logic         put,
  output logic [W-1:0] cnt,
  output logic         ovf
);
  localparam logic [W-1:0] MAXV = W'(MAX);

  // cup without put at MAX is dropped and flagged as overflow
  assign ovf = cup && !put && (cnt == MAXV);

  // count update: +cup -put, equal cup and put cancel out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (cup && !put) begin
      if (cnt != MAXV) cnt <= cnt + 1'b1;
    end else if (put && !cup)
      cnt <= cnt - 1'b1;
  end
endmodule

module tlm_sb_egress_arb #(
  parameter int N_REQ       = 4,
  parameter int PC_CRED_MAX = 8,
  parameter int NP_CRED_MAX = 8
) (
  input  logic               tlm_secondary_clock,
  input  logic               tlm_secondary_reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ-1:0]   req_np,
  input  logic [8*N_REQ-1:0] req_payload,
  input  logic [N_REQ-1:0]   req_eom,
  output logic [N_REQ-1:0]   req_ready,
  input  logic               sb2_tlm_pccup,
  input  logic               sb2_tlm_npcup,
  output logic               tlm_sb2_pcput,
  output logic               tlm_sb2_npput,
  output logic [7:0]         tlm_sb2_payload,
  output logic               tlm_sb2_eom,
  output logic [N_REQ-1:0]   arb_owner,
  output logic               cred_err
`ifdef TLM_SB_ARB_STALL_CNT_EN
  ,
  output logic [15:0]        arb_stall_cnt
`endif
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  logic clk, rst_n;
  assign clk   = tlm_secondary_clock;
  assign rst_n = tlm_secondary_reset;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_q, rr_d, owner_q, owner_d;
  logic            cls_q, cls_d;
  logic            acc, sel_cls;
  logic [PW-1:0]   sel;
  logic [N_REQ-1:0] ready;
  logic            pc_ok, np_ok, pc_ovf, np_ovf;
  logic [$clog2(PC_CRED_MAX+1)-1:0] pc_cnt;
  logic [$clog2(NP_CRED_MAX+1)-1:0] np_cnt;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (int'(p) == N_REQ - 1) ? '0 : p + 1'b1;
  endfunction

  tlm_sb_cred_ctr #(.MAX(PC_CRED_MAX)) u_pc_cred (
    .clk(clk), .rst_n(rst_n), .cup(sb2_tlm_pccup), .put(acc && !sel_cls),
    .cnt(pc_cnt), .ovf(pc_ovf));

  tlm_sb_cred_ctr #(.MAX(NP_CRED_MAX)) u_np_cred (
    .clk(clk), .rst_n(rst_n), .cup(sb2_tlm_npcup), .put(acc && sel_cls),
    .cnt(np_cnt), .ovf(np_ovf));

  assign pc_ok     = (pc_cnt != '0);
  assign np_ok     = (np_cnt != '0);
  assign req_ready = ready;

  // state register and message context
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      cls_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      cls_q   <= cls_d;
    end
  end

  // arbitration: round-robin pick in IDLE, owner-only while LOCKED
  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    cls_d   = cls_q;
    ready   = '0;
    acc     = 1'b0;
    sel     = owner_q;
    sel_cls = cls_q;
    found   = 1'b0;
    idx     = '0;
    case (state_q)
      IDLE: begin
        for (int k = 0; k < N_REQ; k++) begin
          idx = PW'((int'(rr_q) + k) % N_REQ);
          if (!found && req_valid[idx] && (req_np[idx] ? np_ok : pc_ok)) begin
            found   = 1'b1;
            sel     = idx;
            sel_cls = req_np[idx];
          end
        end
        if (found) begin
          acc        = 1'b1;
          ready[sel] = 1'b1;
          cls_d      = sel_cls;
          if (req_eom[sel])
            rr_d = nxt(sel);
          else begin
            state_d = LOCKED;
            owner_d = sel;
          end
        end
      end
      LOCKED: begin
        // req_np is ignored here; the class was fixed by the first flit
        if (req_valid[owner_q] && (cls_q ? np_ok : pc_ok)) begin
          acc            = 1'b1;
          ready[owner_q] = 1'b1;
          if (req_eom[owner_q]) begin
            state_d = IDLE;
            rr_d    = nxt(owner_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // egress register: accepted flit appears one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tlm_sb2_pcput   <= 1'b0;
      tlm_sb2_npput   <= 1'b0;
      tlm_sb2_payload <= '0;
      tlm_sb2_eom     <= 1'b0;
    end else begin
      tlm_sb2_pcput   <= acc && !sel_cls;
      tlm_sb2_npput   <= acc && sel_cls;
      tlm_sb2_payload <= acc ? req_payload[{sel, 3'b000} +: 8] : '0;
      tlm_sb2_eom     <= acc && req_eom[sel];
    end
  end

  // sticky credit overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cred_err <= 1'b0;
    else        cred_err <= cred_err | pc_ovf | np_ovf;
  end

  // owner is only reported while a multi-flit message holds the channel
  always_comb begin
    arb_owner = '0;
    if (state_q == LOCKED) arb_owner[owner_q] = 1'b1;
  end

`ifdef TLM_SB_ARB_STALL_CNT_EN
  logic stall;
  // in IDLE an unaccepted valid can only be blocked by credit
  assign stall = (|req_valid) && !acc &&
                 ((state_q == IDLE) ||
                  (req_valid[owner_q] && !(cls_q ? np_ok : pc_ok)));

  // saturating count of credit-stalled cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             arb_stall_cnt <= '0;
    else if (stall && arb_stall_cnt != '1) arb_stall_cnt <= arb_stall_cnt + 1'b1;
  end
`endif
endmodule
